// File: rtl/ksa_sub_pipe.sv
// Three-stage Kogge-Stone subtractor D = A - B - Bi with borrow-out, signed overflow and zero flags; latency 3, one beat per clock.
// A single global enable (out_ready | ~out_valid) advances every stage; a stalled output freezes the whole pipe and drops in_ready.
module ksa_sub_pipe #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic         Bi,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] D,
    output logic         Bo,
    output logic         Ovf,
    output logic         Z
);

    localparam int L  = $clog2(W);
    localparam int L1 = (L + 1) / 2;

    // stage 1: bitwise propagate/generate of A + ~B + ~Bi
    logic         r1_v;
    logic [W-1:0] r1_p;
    logic [W-1:0] r1_g;
    logic         r1_ci;
    logic         r1_as;
    logic         r1_bs;

    // stage 2: lower half of the prefix levels
    logic         r2_v;
    logic [W-1:0] r2_p;
    logic [W-1:0] r2_gp;
    logic [W-1:0] r2_pp;
    logic         r2_ci;
    logic         r2_as;
    logic         r2_bs;

    // stage 3: registered results driving the outputs
    logic         r3_v;
    logic [W-1:0] r3_d;
    logic         r3_bo;
    logic         r3_ovf;
    logic         r3_z;

    logic         w_adv;
    logic [W-1:0] w_p1;
    logic [W-1:0] w_g1;
    logic [W-1:0] w_g2;
    logic [W-1:0] w_p2;
    logic [W-1:0] w_g3;
    logic [W-1:0] w_p3;
    logic [W-1:0] w_cf;
    logic [W-1:0] w_d;
    logic         w_bo;
    logic         w_ovf;
    logic         w_z;

    assign w_adv    = out_ready | ~r3_v;
    assign in_ready = w_adv;

    assign w_p1 = A ^ ~B;
    assign w_g1 = A & ~B;

    // Each level is a whole-vector span-2^k combine; the shift feeds zeros
    // (G) or ones (P) into the low bits so those positions pass through.
    always_comb begin
        w_g2 = r1_g;
        w_p2 = r1_p;
        for (int k = 0; k < L1; k++) begin
            w_g2 = w_g2 | (w_p2 & (w_g2 << (1 << k)));
            w_p2 = w_p2 & ~((~w_p2) << (1 << k));
        end
    end

    always_comb begin
        w_g3 = r2_gp;
        w_p3 = r2_pp;
        for (int k = L1; k < L; k++) begin
            w_g3 = w_g3 | (w_p3 & (w_g3 << (1 << k)));
            w_p3 = w_p3 & ~((~w_p3) << (1 << k));
        end
    end

    assign w_cf  = w_g3 | (w_p3 & {W{r2_ci}});
    assign w_d   = r2_p ^ {w_cf[W-2:0], r2_ci};
    assign w_bo  = ~w_cf[W-1];
    assign w_ovf = (r2_as ^ r2_bs) & (r2_as ^ w_d[W-1]);
    assign w_z   = ~|w_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r1_v   <= 1'b0;
            r2_v   <= 1'b0;
            r3_v   <= 1'b0;
            r3_d   <= '0;
            r3_bo  <= 1'b0;
            r3_ovf <= 1'b0;
            r3_z   <= 1'b0;
        end else if (w_adv) begin
            r1_v   <= in_valid;
            r2_v   <= r1_v;
            r3_v   <= r2_v;
            r3_d   <= w_d;
            r3_bo  <= w_bo;
            r3_ovf <= w_ovf;
            r3_z   <= w_z;
        end
    end

    // Interior data carries no reset: it is only observed behind a valid bit.
    always_ff @(posedge clk) begin
        if (w_adv) begin
            r1_p  <= w_p1;
            r1_g  <= w_g1;
            r1_ci <= ~Bi;
            r1_as <= A[W-1];
            r1_bs <= B[W-1];
            r2_p  <= r1_p;
            r2_gp <= w_g2;
            r2_pp <= w_p2;
            r2_ci <= r1_ci;
            r2_as <= r1_as;
            r2_bs <= r1_bs;
        end
    end

    assign out_valid = r3_v;
    assign D         = r3_d;
    assign Bo        = r3_bo;
    assign Ovf       = r3_ovf;
    assign Z         = r3_z;

endmodule

// File: tb/tb_ksa_sub_pipe.sv
// Bench for ksa_sub_pipe at W=8/16/32 sharing one handshake; results are checked against plain integer subtraction.
module tb_ksa_sub_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic        Bi;
    logic [31:0] A;
    logic [31:0] B;

    logic        in_ready8, in_ready16, in_ready32;
    logic        out_valid8, out_valid16, out_valid32;
    logic [7:0]  D8;
    logic [15:0] D16;
    logic [31:0] D32;
    logic        Bo8, Bo16, Bo32;
    logic        Ovf8, Ovf16, Ovf32;
    logic        Z8, Z16, Z32;

    ksa_sub_pipe #(.W(8)) u8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready8),
        .A(A[7:0]), .B(B[7:0]), .Bi(Bi), .out_valid(out_valid8), .out_ready(out_ready),
        .D(D8), .Bo(Bo8), .Ovf(Ovf8), .Z(Z8)
    );
    ksa_sub_pipe #(.W(16)) u16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready16),
        .A(A[15:0]), .B(B[15:0]), .Bi(Bi), .out_valid(out_valid16), .out_ready(out_ready),
        .D(D16), .Bo(Bo16), .Ovf(Ovf16), .Z(Z16)
    );
    ksa_sub_pipe #(.W(32)) u32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready32),
        .A(A), .B(B), .Bi(Bi), .out_valid(out_valid32), .out_ready(out_ready),
        .D(D32), .Bo(Bo32), .Ovf(Ovf32), .Z(Z32)
    );

    initial forever #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    // Beats held by the three pipeline stages, oldest at index 2.
    logic        s_v  [3];
    logic [31:0] s_a  [3];
    logic [31:0] s_b  [3];
    logic        s_bi [3];
    logic        known    = 1'b0;
    logic        chk_zero = 1'b0;
    logic [18:0] obs [$];

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, o, e);
        end
    endtask

    function automatic void ref_sub(input int w, input logic [31:0] a, input logic [31:0] b,
                                    input logic bi, output logic [31:0] d,
                                    output logic bo, output logic ov, output logic z);
        longint m    = (longint'(1) << w) - 1;
        longint half = longint'(1) << (w - 1);
        longint ua   = longint'(a) & m;
        longint ub   = longint'(b) & m;
        longint sa   = (ua >= half) ? ua - 2 * half : ua;
        longint sb   = (ub >= half) ? ub - 2 * half : ub;
        longint diff = ua - ub - longint'(bi);
        longint sd   = sa - sb - longint'(bi);
        d  = 32'(diff & m);
        bo = (diff < 0);
        ov = (sd < -half) || (sd >= half);
        z  = ((diff & m) == 0);
    endfunction

    task automatic check_w(input int w, input logic [31:0] d, input logic bo, input logic ov, input logic z);
        logic [31:0] ed;
        logic        ebo, eov, ez;
        ref_sub(w, s_a[2], s_b[2], s_bi[2], ed, ebo, eov, ez);
        chk($sformatf("D_w%0d", w), d, ed);
        chk($sformatf("Bo_w%0d", w), 32'(bo), 32'(ebo));
        chk($sformatf("Ovf_w%0d", w), 32'(ov), 32'(eov));
        chk($sformatf("Z_w%0d", w), 32'(z), 32'(ez));
    endtask

    // One clock: drive inputs, check outputs at the falling edge, advance the model.
    task automatic cyc(input logic rst, input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic bi, input logic r, output logic acc);
        logic exp_adv;
        rst_n = rst; in_valid = v; A = a; B = b; Bi = bi; out_ready = r;
        acc = 1'b0;
        @(negedge clk);
        exp_adv = r | ~s_v[2];
        if (known) begin
            chk("in_ready_w8", 32'(in_ready8), 32'(exp_adv));
            chk("in_ready_w16", 32'(in_ready16), 32'(exp_adv));
            chk("in_ready_w32", 32'(in_ready32), 32'(exp_adv));
            chk("out_valid_w8", 32'(out_valid8), 32'(s_v[2]));
            chk("out_valid_w16", 32'(out_valid16), 32'(s_v[2]));
            chk("out_valid_w32", 32'(out_valid32), 32'(s_v[2]));
            if (chk_zero) begin
                chk("rst_zero_w8", {21'b0, Z8, Ovf8, Bo8, D8}, 32'h0);
                chk("rst_zero_w16", {13'b0, Z16, Ovf16, Bo16, D16}, 32'h0);
                chk("rst_D_w32", D32, 32'h0);
                chk("rst_flags_w32", {29'b0, Z32, Ovf32, Bo32}, 32'h0);
            end
            if (s_v[2]) begin
                check_w(8, {24'b0, D8}, Bo8, Ovf8, Z8);
                check_w(16, {16'b0, D16}, Bo16, Ovf16, Z16);
                check_w(32, D32, Bo32, Ovf32, Z32);
            end
            if (out_valid16 === 1'b1 && r) obs.push_back({Z16, Ovf16, Bo16, D16});
        end
        if (!rst) begin
            known    = 1'b1;
            chk_zero = 1'b1;
            for (int i = 0; i < 3; i++) s_v[i] = 1'b0;
        end else begin
            chk_zero = 1'b0;
            if (known && exp_adv) begin
                acc = v;
                for (int i = 2; i > 0; i--) begin
                    s_v[i] = s_v[i-1]; s_a[i] = s_a[i-1]; s_b[i] = s_b[i-1]; s_bi[i] = s_bi[i-1];
                end
                s_v[0] = v; s_a[0] = a; s_b[0] = b; s_bi[0] = bi;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic r);
        logic acc;
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, r, acc);
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic bi);
        logic acc;
        int   n;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 20) begin
            cyc(1'b1, 1'b1, a, b, bi, 1'b1, acc);
            n++;
        end
        chk("send_accept", 32'(acc), 32'h1);
    endtask

    task automatic chk_obs(input string tag, input int idx, input logic [31:0] e);
        logic [31:0] v;
        v = 'x;
        if (idx < obs.size()) v = 32'(obs[idx]);
        chk(tag, v, e);
    endtask

    initial begin
        logic        acc;
        logic [31:0] bp_a [6];
        logic [31:0] bp_b [6];
        logic        bp_bi [6];
        logic [31:0] ed;
        logic        ebo, eov, ez;
        int          ptr;
        int          nacc;

        for (int i = 0; i < 3; i++) begin
            s_v[i] = 1'b0; s_a[i] = '0; s_b[i] = '0; s_bi[i] = 1'b0;
        end

        // Reset, then one cycle with out_ready low: in_ready still high because nothing is valid.
        cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, acc);
        cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, acc);
        cyc(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, acc);
        idle(2, 1'b1);

        obs.delete();
        send(32'h1234, 32'h0234, 1'b0);
        idle(6, 1'b1);
        chk("single_count", 32'(obs.size()), 32'd1);
        chk_obs("single_res", 0, 32'h01000);

        obs.delete();
        send(32'h0000, 32'h0001, 1'b0);
        send(32'h8000, 32'h0001, 1'b0);
        send(32'h5555, 32'h5554, 1'b1);
        idle(6, 1'b1);
        chk("b2b_count", 32'(obs.size()), 32'd3);
        chk_obs("b2b_0", 0, 32'h1FFFF);
        chk_obs("b2b_1", 1, 32'h27FFF);
        chk_obs("b2b_2", 2, 32'h40000);

        obs.delete();
        send(32'h0000, 32'h0000, 1'b1);
        send(32'hFFFF, 32'hFFFF, 1'b1);
        send(32'h4321, 32'h4321, 1'b0);
        idle(6, 1'b1);
        chk_obs("carry_0", 0, 32'h1FFFF);
        chk_obs("carry_1", 1, 32'h1FFFF);
        chk_obs("equal", 2, 32'h40000);

        // Six beats; the first result is stalled for four cycles.
        bp_a  = '{32'h0010, 32'h7FFF, 32'h8000, 32'h0000, 32'hABCD, 32'h0001};
        bp_b  = '{32'h0001, 32'hFFFF, 32'h7FFF, 32'h0000, 32'h1234, 32'h0002};
        bp_bi = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        ref_sub(16, bp_a[0], bp_b[0], bp_bi[0], ed, ebo, eov, ez);
        obs.delete();
        ptr = 0;
        for (int c = 0; c < 30; c++) begin
            logic stall;
            int   k;
            stall = (c >= 3 && c <= 6);
            k     = (ptr < 6) ? ptr : 0;
            cyc(1'b1, ptr < 6, bp_a[k], bp_b[k], bp_bi[k], !stall, acc);
            if (acc) ptr++;
            if (stall) begin
                chk("stall_valid", 32'(out_valid16), 32'h1);
                chk("stall_hold", {16'b0, D16}, ed);
            end
        end
        chk("bp_count", 32'(obs.size()), 32'd6);
        for (int i = 0; i < 6; i++) begin
            ref_sub(16, bp_a[i], bp_b[i], bp_bi[i], ed, ebo, eov, ez);
            chk_obs($sformatf("bp_order_%0d", i), i, {13'b0, ez, eov, ebo, ed[15:0]});
        end

        // Reset with beats in flight: nothing may emerge afterwards.
        obs.delete();
        cyc(1'b1, 1'b1, 32'h0777, 32'h0111, 1'b0, 1'b1, acc);
        cyc(1'b1, 1'b1, 32'h0999, 32'h0222, 1'b1, 1'b1, acc);
        cyc(1'b0, 1'b1, 32'h0555, 32'h0333, 1'b0, 1'b1, acc);
        cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, acc);
        idle(8, 1'b1);
        chk("reset_flush", 32'(obs.size()), 32'd0);

        nacc = 0;
        for (int c = 0; c < 40000 && nacc < 10000; c++) begin
            logic [31:0] a, b;
            logic        v, r, bi;
            int          sel;
            a   = $urandom;
            b   = $urandom;
            bi  = 1'($urandom_range(0, 1));
            v   = ($urandom_range(0, 3) != 0);
            r   = ($urandom_range(0, 4) != 0);
            sel = $urandom_range(0, 9);
            if (sel == 0) b = a;
            if (sel == 1) begin a = 32'h0; b = 32'h0; end
            if (sel == 2) begin a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; end
            cyc(1'b1, v, a, b, bi, r, acc);
            if (acc) nacc++;
        end
        chk("rand_beats", 32'(nacc), 32'd10000);
        idle(6, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
